uart_rx: RTL

- UART receiver, the downstream consumer of the UART transmitter's TX_OUT serial line.
- Oversamples the line at PRESCALE x bit rate, detects the start bit, shifts in the data bits LSB first, checks optional parity and the stop bit.
- Presents the received byte on P_DATA with a one-cycle Data_Valid strobe.
- Used in the loopback environment (TX_OUT -> RX_IN) and as the device-side receiver.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sampler.sv | 83 ++++++++
 rtl/uart_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Optional majority voting is enabled by UART_RX_MAJORITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PRESCALE   = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, in-bit edge counter and bit resolver.
// UART_RX_MAJORITY_EN selects 2-of-3 voting instead of a single sample.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  input  logic run,
  output logic falling_edge,
  output logic bit_value,
  output logic resolve_strobe,
  output logic bit_end_strobe
);

  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] RES_PT = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] END_PT = EW'(PRESCALE - 1);

  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic [EW-1:0] edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Held at zero while idle so a new frame always starts at count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!run || bit_end_strobe) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + EW'(1);
    end
  end

  assign falling_edge   = sync3 & ~sync2;
  assign resolve_strobe = run && (edge_cnt == RES_PT);
  assign bit_end_strobe = run && (edge_cnt == END_PT);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [EW-1:0] MID_A = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] MID_B = EW'(PRESCALE / 2);

  logic samp_a;
  logic samp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (run && (edge_cnt == MID_A)) begin
        samp_a <= sync2;
      end
      if (run && (edge_cnt == MID_B)) begin
        samp_b <= sync2;
      end
    end
  end

  // Third vote is the live sample at the resolve point.
  assign bit_value = (samp_a & samp_b) |
                     (samp_a & sync2)  |
                     (samp_b & sync2);
`else
  assign bit_value = sync2;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with error pulses.
// Build with UART_RX_MAJORITY_EN for 3-sample majority bit voting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE   = DEF_PRESCALE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  rx_state_e state_q;
  rx_state_e state_d;

  logic                  falling_edge;
  logic                  bit_value;
  logic                  resolve;
  logic                  bit_end;
  logic                  run;
  logic                  load_cfg;
  logic                  done;
  logic                  frame_ok;
  logic                  exp_par;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  pe_q;
  logic                  pt_q;
  logic                  par_bad_q;

  assign run = (state_q != IDLE);

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk           (CLK),
    .rst_n         (RST),
    .rx_in         (RX_IN),
    .run           (run),
    .falling_edge  (falling_edge),
    .bit_value     (bit_value),
    .resolve_strobe(resolve),
    .bit_end_strobe(bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (falling_edge) begin
          state_d  = START;
          load_cfg = 1'b1;
        end
      end
      START: begin
        if (resolve && bit_value) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt_q == LAST)) begin
          state_d = pe_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave mid-bit so the next start edge is never missed.
        if (resolve) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign exp_par  = (^shreg_q) ^ (pt_q == PARITY_ODD);
  assign frame_ok = bit_value & ~(pe_q & par_bad_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      pe_q      <= 1'b0;
      pt_q      <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      if (load_cfg) begin
        pe_q      <= parity_enable;
        pt_q      <= parity_type;
        par_bad_q <= 1'b0;
        bit_cnt_q <= '0;
      end
      if ((state_q == DATA) && resolve) begin
        shreg_q[bit_cnt_q] <= bit_value;
      end
      if ((state_q == DATA) && bit_end) begin
        bit_cnt_q <= (bit_cnt_q == LAST) ? '0 : bit_cnt_q + BW'(1);
      end
      if ((state_q == PARITY) && resolve) begin
        par_bad_q <= (bit_value != exp_par);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      Data_Valid   <= done & frame_ok;
      parity_error <= done & pe_q & par_bad_q;
      stop_error   <= done & ~bit_value;
      busy         <= (state_d != IDLE);
      if (done && frame_ok) begin
        P_DATA <= shreg_q;
      end
    end
  end

endmodule
